// File: rtl/button_pkg.sv
// Shared types and default constants for the pushbutton debouncer.
//   btn_state_e         : debounce FSM states
//   CLK_HZ              : board clock frequency
//   DEBOUNCE_CYCLES_DEF : 10 ms stability window at CLK_HZ
//   LONG_CYCLES_DEF     : 1 s long-press threshold at CLK_HZ
//   PRESS_CNT_W         : width of the exported press counter (LED4..LED0)
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_e;

  localparam int unsigned CLK_HZ              = 12_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;
  localparam int unsigned LONG_CYCLES_DEF     = CLK_HZ;
  localparam int unsigned PRESS_CNT_W         = 5;

endpackage

// File: rtl/sync_ff.sv
// N-stage synchronizer for asynchronous board inputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized output (last stage)
// Stages reset to RESET_VAL so an idle pin looks idle from the first cycle.
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // Shift chain; stage 0 captures the raw pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Pushbutton debouncer: synchronizes the raw pin, requires DEBOUNCE_CYCLES
// stable cycles to accept a level change, and emits registered events.
//   clk, rst_n    : 12 MHz board clock, asynchronous active-low reset
//   btn           : raw button pin, asynchronous to clk
//   btn_level     : debounced level, 1 = pressed
//   press_pulse   : one-cycle strobe on accepted press
//   release_pulse : one-cycle strobe on accepted release
//   long_pulse    : one-cycle strobe LONG_CYCLES after press, once per press
//   press_count   : accepted presses modulo 32, cleared by long_pulse
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn,
  output logic                   btn_level,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic                   long_pulse,
  output logic [PRESS_CNT_W-1:0] press_count
);

  localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned LONG_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);

  logic btn_sync;
  logic synced;

  btn_state_e             state, state_d;
  logic [DEB_W-1:0]       deb_cnt, deb_cnt_d;
  logic [LONG_W-1:0]      long_cnt, long_cnt_d;
  logic                   level_d, press_d, release_d, long_d;
  logic [PRESS_CNT_W-1:0] count_d;

  sync_ff #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (BTN_ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn),
    .q     (btn_sync)
  );

  // Normalize to 1 = pressed after the last synchronizer stage.
  assign synced = BTN_ACTIVE_LOW ? ~btn_sync : btn_sync;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      deb_cnt       <= '0;
      long_cnt      <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= '0;
    end else begin
      state         <= state_d;
      deb_cnt       <= deb_cnt_d;
      long_cnt      <= long_cnt_d;
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
      press_count   <= count_d;
    end
  end

  // Next-state, counter updates and next output values.
  always_comb begin
    state_d    = state;
    deb_cnt_d  = deb_cnt;
    long_cnt_d = long_cnt;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    count_d    = press_count;

    unique case (state)
      IDLE: begin
        if (synced) begin
          state_d   = PRESS_PEND;
          deb_cnt_d = '0;
        end
      end
      PRESS_PEND: begin
        if (!synced) begin
          state_d = IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          state_d    = PRESSED;
          press_d    = 1'b1;
          long_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt + DEB_W'(1);
        end
      end
      PRESSED: begin
        if (!synced) begin
          state_d   = RELEASE_PEND;
          deb_cnt_d = '0;
        end
      end
      RELEASE_PEND: begin
        if (synced) begin
          state_d = PRESSED;
        end else if (deb_cnt == DEB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt + DEB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Long-press timer runs while the debounced level is pressed and
    // saturates after firing so it cannot repeat within one press.
    if ((state == PRESSED || state == RELEASE_PEND) && long_cnt != LONG_SAT) begin
      long_cnt_d = long_cnt + LONG_W'(1);
      if (long_cnt == LONG_LAST) begin
        long_d = 1'b1;
      end
    end

    // Press and long strobes are mutually exclusive by construction.
    if (press_d) begin
      count_d = press_count + PRESS_CNT_W'(1);
    end else if (long_d) begin
      count_d = '0;
    end

    level_d = (state_d == PRESSED) || (state_d == RELEASE_PEND);
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed scoreboard bench for button_debounce (DEBOUNCE=4, LONG=10, 2 stages).
module tb_button_debounce;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 10;

  localparam logic [2:0] K_PRESS   = 3'b001;
  localparam logic [2:0] K_RELEASE = 3'b010;
  localparam logic [2:0] K_LONG    = 3'b100;

  typedef struct {
    logic [2:0]  kind;
    int unsigned at;
    logic [4:0]  count;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn;
  logic       btn_level, press_pulse, release_pulse, long_pulse;
  logic [4:0] press_count;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  ev_t         sb[$];
  logic [4:0]  exp_cnt;
  logic [4:0]  cur_count = '0;
  logic        cur_level = 1'b0;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG),
    .SYNC_STAGES     (2),
    .BTN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn           (btn),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .press_count   (press_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic push(input logic [2:0] kind, input int unsigned at, input logic [4:0] count);
    ev_t e;
    e.kind  = kind;
    e.at    = at;
    e.count = count;
    sb.push_back(e);
  endtask

  // Advance n edges and land 1 time unit after the last one.
  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press held 8 cycles (well under LONG), then released cleanly.
  task automatic short_press();
    int unsigned b;
    b       = cyc;
    btn     = 1'b0;
    exp_cnt = exp_cnt + 5'd1;
    push(K_PRESS, b + 7, exp_cnt);
    go(8);
    btn = 1'b1;
    push(K_RELEASE, b + 15, exp_cnt);
    go(9);
  endtask

  // Output monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      while (sb.size() > 0 && sb[0].at < cyc) begin
        check("missing_event_cycle", cyc, sb[0].at);
        void'(sb.pop_front());
      end
      if (press_pulse || release_pulse || long_pulse) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", {29'd0, long_pulse, release_pulse, press_pulse}, 32'd0);
        end else begin
          ev_t e;
          e = sb.pop_front();
          check("strobe_kind", {29'd0, long_pulse, release_pulse, press_pulse}, {29'd0, e.kind});
          check("strobe_cycle", cyc, e.at);
          cur_count = e.count;
          if (e.kind == K_PRESS)   cur_level = 1'b1;
          if (e.kind == K_RELEASE) cur_level = 1'b0;
        end
      end
      check("btn_level", {31'd0, btn_level}, {31'd0, cur_level});
      check("press_count", {27'd0, press_count}, {27'd0, cur_count});
    end
  end

  initial begin
    int unsigned b;
    rst_n   = 1'b0;
    btn     = 1'b1;
    exp_cnt = '0;
    #1;
    check("reset_outputs", {26'd0, btn_level, press_pulse, release_pulse, long_pulse, press_count}, 32'd0);
    go(3);
    check("reset_outputs_held", {26'd0, btn_level, press_pulse, release_pulse, long_pulse, press_count}, 32'd0);
    rst_n = 1'b1;
    go(4);

    // Clean press and release.
    short_press();

    // Bounce: 3 low cycles is too short to be accepted.
    btn = 1'b0;
    go(3);
    btn = 1'b1;
    go(10);
    // Follow-up press after the bounce is accepted normally.
    short_press();

    // Long press with a 2-cycle release glitch that must not disturb timing.
    b       = cyc;
    btn     = 1'b0;
    exp_cnt = exp_cnt + 5'd1;
    push(K_PRESS, b + 7, exp_cnt);
    exp_cnt = '0;
    push(K_LONG, b + 17, exp_cnt);
    go(10);
    btn = 1'b1;
    go(2);
    btn = 1'b0;
    go(18);
    btn = 1'b1;
    push(K_RELEASE, b + 37, exp_cnt);
    go(10);

    // Wrap-around of the 5-bit press counter.
    for (int i = 0; i < 33; i++) begin
      short_press();
    end
    check("count_after_wrap", {27'd0, press_count}, 32'd1);

    // Reset while in PRESS_PEND with the button held.
    btn = 1'b0;
    go(4);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {26'd0, btn_level, press_pulse, release_pulse, long_pulse, press_count}, 32'd0);
    sb.delete();
    exp_cnt   = '0;
    cur_count = '0;
    cur_level = 1'b0;
    go(3);
    rst_n = 1'b1;
    b       = cyc;
    exp_cnt = 5'd1;
    push(K_PRESS, b + 7, exp_cnt);
    go(8);
    btn = 1'b1;
    push(K_RELEASE, b + 15, exp_cnt);
    go(10);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
